// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage behind the ALU.
// Holds the NZCV flag register and evaluates the ARM condition field against
// the stored flags. It also gates PC, register-file and memory writes so that
// an instruction whose condition fails has no architectural effect.
// Optional build macro COND_PERF_CNT_EN adds executed/skipped instruction
// counters with an Instr_Valid qualifier.
module cond_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NoWrite,
    input  logic        Stall,
`ifdef COND_PERF_CNT_EN
    input  logic        Instr_Valid,
    output logic [31:0] Exec_Count,
    output logic [31:0] Skip_Count,
`endif
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic [3:0]  Flags
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_condEx;
    logic       w_commit;
    cond_t      w_cond;

    assign w_n    = r_flags[3];
    assign w_z    = r_flags[2];
    assign w_c    = r_flags[1];
    assign w_v    = r_flags[0];
    assign w_cond = cond_t'(Cond);

    // Condition check uses only the stored flags, never this instruction's ALU result
    always_comb begin
        w_condEx = 1'b0;
        case (w_cond)
            COND_EQ: w_condEx = w_z;
            COND_NE: w_condEx = ~w_z;
            COND_CS: w_condEx = w_c;
            COND_CC: w_condEx = ~w_c;
            COND_MI: w_condEx = w_n;
            COND_PL: w_condEx = ~w_n;
            COND_VS: w_condEx = w_v;
            COND_VC: w_condEx = ~w_v;
            COND_HI: w_condEx = w_c & ~w_z;
            COND_LS: w_condEx = ~w_c | w_z;
            COND_GE: w_condEx = (w_n == w_v);
            COND_LT: w_condEx = (w_n != w_v);
            COND_GT: w_condEx = ~w_z & (w_n == w_v);
            COND_LE: w_condEx = w_z | (w_n != w_v);
            COND_AL: w_condEx = 1'b1;
            COND_NV: w_condEx = 1'b0;
            default: w_condEx = 1'b0;
        endcase
    end

    // An instruction commits only when its condition passes and the pipe is not stalled
    assign w_commit = w_condEx & ~Stall;

    assign CondEx   = w_condEx;
    assign Flags    = r_flags;
    assign PCSrc    = PCS & w_commit;
    assign RegWrite = RegW & ~NoWrite & w_commit;
    assign MemWrite = MemW & w_commit;

    // Flag register: N,Z and C,V halves update independently so logical ops keep C,V
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_flags <= 4'b0000;
        end else begin
            if (FlagW[1] && w_commit) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && w_commit) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [31:0] r_execCount;
    logic [31:0] r_skipCount;
    logic        w_countEn;

    assign w_countEn  = Instr_Valid & ~Stall;
    assign Exec_Count = r_execCount;
    assign Skip_Count = r_skipCount;

    // Saturating counters of executed vs. condition-failed instructions
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_execCount <= 32'd0;
            r_skipCount <= 32'd0;
        end else if (w_countEn) begin
            if (w_condEx) begin
                if (r_execCount != 32'hFFFF_FFFF) begin
                    r_execCount <= r_execCount + 32'd1;
                end
            end else begin
                if (r_skipCount != 32'hFFFF_FFFF) begin
                    r_skipCount <= r_skipCount + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit.
// Stimulus pushes hand-computed expectations into a queue; a monitor process
// pops one entry each time a vector is presented and compares at the falling
// edge. Counter checks are compiled in when COND_PERF_CNT_EN is defined.
module tb_cond_unit;

    typedef struct {
        string      label;
        logic       condEx;
        logic       pcSrc;
        logic       regWrite;
        logic       memWrite;
        logic [3:0] flags;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  cond;
    logic [3:0]  aluFlags;
    logic [1:0]  flagW;
    logic        pcs;
    logic        regW;
    logic        memW;
    logic        noWrite;
    logic        stall;
    logic        instrValid;
    logic        pcSrc;
    logic        regWrite;
    logic        memWrite;
    logic        condEx;
    logic [3:0]  flags;
`ifdef COND_PERF_CNT_EN
    logic [31:0] execCount;
    logic [31:0] skipCount;
`endif

    exp_t expQ[$];
    logic sampleReq;
    int   checks;
    int   errors;

    cond_unit dut (
        .CLK         (clock),
        .RESET       (reset),
        .Cond        (cond),
        .ALUFlags    (aluFlags),
        .FlagW       (flagW),
        .PCS         (pcs),
        .RegW        (regW),
        .MemW        (memW),
        .NoWrite     (noWrite),
        .Stall       (stall),
`ifdef COND_PERF_CNT_EN
        .Instr_Valid (instrValid),
        .Exec_Count  (execCount),
        .Skip_Count  (skipCount),
`endif
        .PCSrc       (pcSrc),
        .RegWrite    (regWrite),
        .MemWrite    (memWrite),
        .CondEx      (condEx),
        .Flags       (flags)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one vector just after a rising edge and queue its expected outputs
    task automatic applyStimulus(
        input string      label,
        input logic       rst,
        input logic [3:0] c,
        input logic [3:0] alu,
        input logic [1:0] fw,
        input logic       p,
        input logic       rw,
        input logic       mw,
        input logic       nw,
        input logic       st,
        input logic       vld,
        input logic       eCondEx,
        input logic       ePcSrc,
        input logic       eRegWrite,
        input logic       eMemWrite,
        input logic [3:0] eFlags
    );
        exp_t e;
        @(posedge clock);
        #1;
        reset      = rst;
        cond       = c;
        aluFlags   = alu;
        flagW      = fw;
        pcs        = p;
        regW       = rw;
        memW       = mw;
        noWrite    = nw;
        stall      = st;
        instrValid = vld;
        e.label    = label;
        e.condEx   = eCondEx;
        e.pcSrc    = ePcSrc;
        e.regWrite = eRegWrite;
        e.memWrite = eMemWrite;
        e.flags    = eFlags;
        expQ.push_back(e);
        sampleReq  = 1'b1;
    endtask

    // Compare sampled DUT outputs against one scoreboard entry
    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        logic [7:0] req;
        act = {condEx, pcSrc, regWrite, memWrite, flags};
        req = {e.condEx, e.pcSrc, e.regWrite, e.memWrite, e.flags};
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: {CondEx,PCSrc,RegWrite,MemWrite,Flags} got %b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     e.label, act[7], act[6], act[5], act[4], act[3:0],
                     req[7], req[6], req[5], req[4], req[3:0]);
        end
    endtask

    // Compare a 32-bit counter value against its required value
    task automatic checkCount(input string label, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", label, act, req);
        end
    endtask

    // Monitor: on the falling edge after a vector is presented, pop and compare
    always @(negedge clock) begin
        if (sampleReq) begin
            sampleReq = 1'b0;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Watchdog so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence
    initial begin
        reset      = 1'b1;
        cond       = 4'b1110;
        aluFlags   = 4'b0000;
        flagW      = 2'b00;
        pcs        = 1'b0;
        regW       = 1'b0;
        memW       = 1'b0;
        noWrite    = 1'b0;
        stall      = 1'b1;
        instrValid = 1'b0;
        sampleReq  = 1'b0;
        checks     = 0;
        errors     = 0;

        //            label          rst cond     alu      fw     pcs  rw   mw   nw   st   vld    cEx  pc   rwE  mwE  flags
        applyStimulus("reset_hold",  1, 4'b1110, 4'b0000, 2'b00, 0,   1,   0,   0,   1,   0,     1,   0,   0,   0,   4'b0000);
        applyStimulus("eq_after_rst",0, 4'b0000, 4'b0000, 2'b00, 0,   1,   0,   0,   0,   0,     0,   0,   0,   0,   4'b0000);
        applyStimulus("ne_after_rst",0, 4'b0001, 4'b0000, 2'b00, 0,   1,   0,   0,   0,   0,     1,   0,   1,   0,   4'b0000);
        applyStimulus("al_set_0110", 0, 4'b1110, 4'b0110, 2'b11, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b0000);
        applyStimulus("eq_z1",       0, 4'b0000, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b0110);
        applyStimulus("hi_c1_z1",    0, 4'b1000, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     0,   0,   0,   0,   4'b0110);
        applyStimulus("al_set_1001", 0, 4'b1110, 4'b1001, 2'b11, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b0110);
        applyStimulus("al_nz_only",  0, 4'b1110, 4'b0100, 2'b10, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b1001);
        applyStimulus("ge_partial",  0, 4'b1010, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     0,   0,   0,   0,   4'b0101);
        applyStimulus("le_all_wr",   0, 4'b1101, 4'b0000, 2'b00, 1,   1,   1,   0,   0,   0,     1,   1,   1,   1,   4'b0101);
        applyStimulus("al_clear",    0, 4'b1110, 4'b0000, 2'b11, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b0101);
        applyStimulus("eq_fail",     0, 4'b0000, 4'b1111, 2'b11, 1,   0,   1,   0,   0,   0,     0,   0,   0,   0,   4'b0000);
        applyStimulus("fail_no_upd", 0, 4'b1110, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     1,   0,   0,   0,   4'b0000);
        applyStimulus("cmp_nowrite", 0, 4'b1110, 4'b1000, 2'b11, 0,   1,   0,   1,   0,   0,     1,   0,   0,   0,   4'b0000);
        applyStimulus("stall_gate",  0, 4'b1110, 4'b0111, 2'b11, 1,   1,   1,   0,   1,   0,     1,   0,   0,   0,   4'b1000);
        applyStimulus("mi_n1",       0, 4'b0100, 4'b0000, 2'b00, 0,   1,   0,   0,   0,   0,     1,   0,   1,   0,   4'b1000);
        applyStimulus("nv_never",    0, 4'b1111, 4'b0000, 2'b00, 1,   1,   1,   0,   0,   0,     0,   0,   0,   0,   4'b1000);
        applyStimulus("lt_n_ne_v",   0, 4'b1011, 4'b0000, 2'b00, 0,   0,   1,   0,   0,   0,     1,   0,   0,   1,   4'b1000);
        applyStimulus("gt_n_ne_v",   0, 4'b1100, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     0,   0,   0,   0,   4'b1000);
        applyStimulus("async_reset", 1, 4'b1110, 4'b0000, 2'b00, 0,   1,   0,   0,   1,   0,     1,   0,   0,   0,   4'b0000);
        applyStimulus("rst_al_pass", 1, 4'b1110, 4'b0000, 2'b00, 0,   1,   0,   0,   0,   0,     1,   0,   1,   0,   4'b0000);
        applyStimulus("eq_post_rst", 0, 4'b0000, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   0,     0,   0,   0,   0,   4'b0000);

        // Counter workload: five executed, three skipped, two stalled
        for (int i = 0; i < 5; i++) begin
            applyStimulus("cnt_al",  0, 4'b1110, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   1,     1,   0,   0,   0,   4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("cnt_eq",  0, 4'b0000, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   1,     0,   0,   0,   0,   4'b0000);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus("cnt_stall",0,4'b1110, 4'b0000, 2'b00, 0,   1,   0,   0,   1,   1,     1,   0,   0,   0,   4'b0000);
        end
        @(posedge clock);
        #1;
        instrValid = 1'b0;
`ifdef COND_PERF_CNT_EN
        checkCount("exec_count", execCount, 32'd5);
        checkCount("skip_count", skipCount, 32'd3);
        force dut.r_execCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_execCount;
`endif
        applyStimulus("cnt_sat_al",  0, 4'b1110, 4'b0000, 2'b00, 0,   0,   0,   0,   0,   1,     1,   0,   0,   0,   4'b0000);
        @(posedge clock);
        #1;
        instrValid = 1'b0;
`ifdef COND_PERF_CNT_EN
        checkCount("exec_saturate", execCount, 32'hFFFF_FFFF);
        checkCount("skip_held", skipCount, 32'd3);
`endif

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && (expQ.size() != 0 || sampleReq); i++) begin
            @(posedge clock);
        end
        if (expQ.size() != 0 || sampleReq) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage that sits directly downstream of the ALU.
- Holds the architectural NZCV flag register and updates it from ALUFlags ({N,Z,C,V}) under control of the decoder.
- Evaluates the 4-bit ARM condition field of the current instruction against the stored flags.
- Gates PC, register-file and memory writes so that instructions whose condition fails have no architectural effect.

Parameters:
- None.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from ALU of the current instruction.
- FlagW  input  2  flag write enables from decoder: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  instruction writes PC (branch or Rd=R15).
- RegW  input  1  instruction writes register file.
- MemW  input  1  instruction writes data memory.
- NoWrite  input  1  compare-class op (CMP/CMN): suppresses register write.
- Stall  input  1  pipeline/multicycle stall; current instruction not committing this cycle.
- PCSrc  output  1  gated PC write select.
- RegWrite  output  1  gated register write enable.
- MemWrite  output  1  gated memory write enable.
- CondEx  output  1  condition passed, evaluated on stored flags.
- Flags  output  4  current stored {N,Z,C,V}.

Behaviour:
- Flag register: 4 bits {N,Z,C,V}. RESET asynchronously clears it to 4'b0000.
- CondEx is combinational from Cond and the stored Flags, never from ALUFlags:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 0 (reserved, treated as never).
- Gated outputs, all combinational with zero latency:
  - PCSrc = PCS & CondEx & ~Stall.
  - RegWrite = RegW & CondEx & ~NoWrite & ~Stall.
  - MemWrite = MemW & CondEx & ~Stall.
- Flag update at rising CLK:
  - N,Z <= ALUFlags[3:2] when FlagW[1] & CondEx & ~Stall.
  - C,V <= ALUFlags[1:0] when FlagW[0] & CondEx & ~Stall.
  - Each half is independent; a partial update (e.g. logical op with FlagW=2'b10) leaves the other two bits unchanged.
- New flags are visible on Flags and CondEx starting the cycle after the update (one-cycle latency). The same instruction's own CondEx uses the pre-update flags.
- Failed condition: no flag update and all gated outputs 0, regardless of FlagW, PCS, RegW or MemW.
- Stall=1: flags held and all gated outputs 0. CondEx still reflects Cond vs stored flags so other logic can observe it.
- RESET asserted mid-operation clears flags immediately and asynchronously. During reset, outputs follow the reset flag value: with Cond=AL and Stall=0, writes still pass combinationally. The bench must hold Stall=1 during reset.
- Width rules: no arithmetic on flags; all comparisons are single-bit.

Optional Feature:
- Macro COND_PERF_CNT_EN.
- When defined, adds these ports:
  - Instr_Valid  input  1  an instruction is presented this cycle.
  - Exec_Count  output  32  count of executed instructions.
  - Skip_Count  output  32  count of skipped instructions.
- On each rising CLK with Instr_Valid & ~Stall:
  - Exec_Count increments if CondEx=1.
  - Skip_Count increments if CondEx=0.
- Both counters saturate at 32'hFFFF_FFFF (no wrap) and reset asynchronously to 0.
- When undefined: ports and counters are absent and core behaviour is identical.

Test Plan:
- Reset, then Cond=0000 (EQ) with RegW=1 -> CondEx=0, RegWrite=0, Flags=0000. Cond=0001 (NE) -> CondEx=1, RegWrite=1.
- Cond=1110, FlagW=2'b11, ALUFlags=0110, one clock edge -> Flags=0110. Next cycle Cond=0000 -> CondEx=1; Cond=1000 (HI) -> CondEx=0 (C=1, Z=1).
- Flags=1001, Cond=1110, FlagW=2'b10, ALUFlags=0100 -> after edge Flags=0101 (C,V retained).
- Flags=0000, Cond=0000, FlagW=2'b11, ALUFlags=1111, PCS=MemW=1 -> CondEx=0, PCSrc=0, MemWrite=0, Flags stays 0000 after edge.
- Cond=1110, RegW=1, NoWrite=1, FlagW=2'b11, ALUFlags=1000 -> RegWrite=0, Flags=1000 after edge. Repeat with Stall=1 -> Flags unchanged and all gated outputs 0.
- COND_PERF_CNT_EN: 5 valid AL instructions plus 3 valid EQ instructions with Z=0, plus 2 stalled instructions -> Exec_Count=5, Skip_Count=3. Preload via force to FFFF_FFFF, one more AL instruction -> Exec_Count stays FFFF_FFFF.
